// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program-counter fetch stage with redirect, stall, imem handshake
//            and halt; optional misaligned-redirect trap (PC_MISALIGN_TRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
    parameter int          n            = 32,
    parameter logic [n-1:0] RESET_VECTOR = {n{1'b0}},
    parameter logic [n-1:0] TRAP_VECTOR  = n'(32'h0000_0080)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] pc_plus4,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [n-1:0] redirect_target,
    input  logic         halt,
    input  logic         imem_ready,
    output logic [n-1:0] pc,
    output logic         fetch_valid,
    output logic         halted,
    output logic         misalign_trap
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [n-1:0] r_pc;
    logic [n-1:0] w_pc_next;
    logic         r_fetch_valid;
    logic         r_halted;
    logic         r_pend_valid;
    logic         w_pend_valid_next;
    logic [n-1:0] r_pend_target;
    logic [n-1:0] w_pend_target_next;
    logic         w_trap_next;

    logic         w_adv;
    logic         w_redir_sel;
    logic [n-1:0] w_redir_target;

    // A fetch is consumed only when presented, accepted and not frozen.
    assign w_adv          = (r_state == S_RUN) & imem_ready & ~stall;
    assign w_redir_sel    = redirect_valid | r_pend_valid;
    assign w_redir_target = redirect_valid ? redirect_target : r_pend_target;

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_pend_valid_next  = r_pend_valid;
        w_pend_target_next = r_pend_target;
        w_trap_next        = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                if (halt) begin
                    w_state_next      = S_HALTED;
                    w_pend_valid_next = 1'b0;
                end else if (w_adv) begin
                    w_pend_valid_next = 1'b0;
                    if (w_redir_sel) begin
`ifdef PC_MISALIGN_TRAP_EN
                        if (|w_redir_target[1:0]) begin
                            w_pc_next   = TRAP_VECTOR;
                            w_trap_next = 1'b1;
                        end else begin
                            w_pc_next = w_redir_target;
                        end
`else
                        w_pc_next = {w_redir_target[n-1:2], 2'b00};
`endif
                    end else begin
                        w_pc_next = pc_plus4;
                    end
                end else if (redirect_valid) begin
                    // Held until the current fetch is accepted; newest wins.
                    w_pend_valid_next  = 1'b1;
                    w_pend_target_next = redirect_target;
                end
            end
            S_HALTED: begin
                w_state_next = S_HALTED;
            end
            default: begin
                w_state_next = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_VECTOR;
            r_fetch_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= {n{1'b0}};
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_fetch_valid <= (w_state_next == S_RUN);
            r_halted      <= (w_state_next == S_HALTED);
            r_pend_valid  <= w_pend_valid_next;
            r_pend_target <= w_pend_target_next;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic r_trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap <= 1'b0;
        end else begin
            r_trap <= w_trap_next;
        end
    end

    assign misalign_trap = r_trap;
`else
    logic w_unused;
    assign w_unused      = ^{TRAP_VECTOR, w_trap_next};
    assign misalign_trap = 1'b0;
`endif

    assign pc          = r_pc;
    assign fetch_valid = r_fetch_valid;
    assign halted      = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed vector table, then randomized
// stimulus against a behavioural model; adder (pc + 4) modelled in the bench.
`default_nettype none

module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        imem_ready;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        halted;
    logic        misalign_trap;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(
        .n            (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0080)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_plus4        (pc_plus4),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .imem_ready      (imem_ready),
        .pc              (pc),
        .fetch_valid     (fetch_valid),
        .halted          (halted),
        .misalign_trap   (misalign_trap)
    );

    assign pc_plus4 = pc + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] E14 = 32'h80;
    localparam logic [31:0] E15 = 32'h84;
    localparam logic        T14 = 1'b1;
`else
    localparam logic [31:0] E14 = 32'h100;
    localparam logic [31:0] E15 = 32'h104;
    localparam logic        T14 = 1'b0;
`endif

    typedef struct {
        logic        s;
        logic        rv;
        logic [31:0] rt;
        logic        h;
        logic        r;
        logic [31:0] pc;
        logic        fv;
        logic        hd;
        logic        tr;
    } vec_t;

    vec_t tbl[24];

    // Behavioural reference state
    logic [31:0] m_pc;
    logic        m_booted;
    logic        m_halted;
    logic        m_trap;
    logic [31:0] m_pend[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] epc, input logic efv,
                           input logic ehd, input logic etr);
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, efv});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, ehd});
        chk({tag, ".misalign_trap"}, {31'd0, misalign_trap}, {31'd0, etr});
    endtask

    task automatic drive(input logic s, input logic rv, input logic [31:0] rt,
                         input logic h, input logic r);
        stall           = s;
        redirect_valid  = rv;
        redirect_target = rt;
        halt            = h;
        imem_ready      = r;
    endtask

    function automatic void model_reset();
        m_pc     = 32'h0;
        m_booted = 1'b0;
        m_halted = 1'b0;
        m_trap   = 1'b0;
        m_pend.delete();
    endfunction

    // One clock edge of the fetch rules, computed from current inputs.
    function automatic void model_edge();
        logic [31:0] t;
        m_trap = 1'b0;
        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (m_halted) begin
            // frozen until reset
        end else if (halt) begin
            m_halted = 1'b1;
            m_pend.delete();
        end else if (imem_ready && !stall) begin
            if (redirect_valid || m_pend.size() > 0) begin
                t = redirect_valid ? redirect_target : m_pend[0];
`ifdef PC_MISALIGN_TRAP_EN
                if (t % 4 != 0) begin
                    m_pc   = 32'h80;
                    m_trap = 1'b1;
                end else begin
                    m_pc = t;
                end
`else
                m_pc = t - (t % 4);
`endif
            end else begin
                m_pc = m_pc + 32'd4;
            end
            m_pend.delete();
        end else if (redirect_valid) begin
            m_pend.delete();
            m_pend.push_back(redirect_target);
        end
    endfunction

    // Async reset pulse placed between clock edges; checked while asserted.
    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all(tag, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC,        1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h4,        1'b0, 1'b1, 32'h4,        1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'h100,      1'b0, 1'b0, 32'h4,        1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h4,        1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100,      1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h104,      1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 32'h102,      1'b0, 1'b1, E14,          1'b1, 1'b0, T14};
        tbl[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, E15,          1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 32'h200,      1'b0, 1'b1, E15,          1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 32'h300,      1'b0, 1'b1, E15,          1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h300,      1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 32'h400,      1'b0, 1'b1, 32'h300,      1'b1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h400,      1'b1, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b1, 32'h10,       1'b0, 1'b1, 32'h10,       1'b1, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       1'b0, 1'b1, 1'b0};
        tbl[23] = '{1'b0, 1'b1, 32'h500,      1'b0, 1'b1, 32'h10,       1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_all("boot", 32'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(tbl[i].s, tbl[i].rv, tbl[i].rt, tbl[i].h, tbl[i].r);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].fv, tbl[i].hd, tbl[i].tr);
        end

        // Halted core ignores further input, then reset clears it mid-cycle.
        mid_reset("halt_reset");

        // Randomized run against the reference model.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] t;
            @(negedge clk);
            t = $urandom();
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), t,
                  ($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0));
            model_edge();
            @(posedge clk);
            #1;
            chk_all("rand", m_pc, m_booted && !m_halted, m_halted, m_trap);
            if ($urandom_range(0, 59) == 0) mid_reset("rand_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage that sits directly upstream of the PC-increment adder.
- Its `pc` output drives adder operand `a`; adder operand `b` is tied to 4.
- The adder `sum` returns on `pc_plus4` and becomes the sequential next PC.
- It also handles branch/jump redirects, hazard stalls, the instruction-memory valid/ready handshake and halt.

Parameters:
- `n`, 32, datapath/PC width; must match the adder's `n`.
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset.
- `TRAP_VECTOR`, 32'h0000_0080, misalignment trap target. Used only when `PC_MISALIGN_TRAP_EN` is defined.

Ports:
- `clk`, input, 1, rising-edge clock.
- `rst_n`, input, 1, asynchronous active-low reset.
- `pc_plus4`, input, n, adder `sum` (pc + 4).
- `stall`, input, 1, hazard unit freeze; inhibits PC advance.
- `redirect_valid`, input, 1, branch/jump taken this cycle.
- `redirect_target`, input, n, redirect destination.
- `halt`, input, 1, stop fetching.
- `imem_ready`, input, 1, instruction memory accepts the current fetch.
- `pc`, output, n, current fetch address; drives adder `a` and imem address.
- `fetch_valid`, output, 1, fetch request valid.
- `halted`, output, 1, core halted.
- `misalign_trap`, output, 1, one-cycle trap pulse. Constant 0 when the macro is not defined.

Behaviour:
- Reset (`rst_n`=0, async):
  - `pc`=`RESET_VECTOR`, `fetch_valid`=0, `halted`=0, `misalign_trap`=0.
  - `pend_valid`=0, `pend_target`=0, state=BOOT.
- State BOOT: first clock edge after reset release moves to RUN with `fetch_valid`=1; `pc` unchanged. No fetch occurs in BOOT.
- State RUN:
  - `fetch_valid`=1.
  - adv = `fetch_valid` & `imem_ready` & ~`stall`.
  - Priority at each edge, highest first:
    1. `halt`=1 → HALTED; `pc` holds; `fetch_valid`=0; `halted`=1. Any pending redirect is discarded.
    2. adv=1 → `pc` <= `redirect_valid` ? `redirect_target` : `pend_valid` ? `pend_target` : `pc_plus4`. Clear `pend_valid`.
    3. adv=0 and `redirect_valid`=1 → `pend_target` <= `redirect_target`; `pend_valid` <= 1. A newer redirect overwrites an older pending one. `pc` holds.
    4. Otherwise `pc` holds.
- Handshake rule: while `fetch_valid`=1 and adv=0, `pc` is stable. A redirect never changes `pc` until the presented fetch is accepted.
- Latency:
  - Accepted fetch → next address visible one cycle later.
  - Redirect with adv=1 takes effect the next cycle.
  - Otherwise it takes effect on the cycle after the first subsequent adv.
- State HALTED: `pc`, `halted`=1 and `fetch_valid`=0 hold; all inputs ignored; exit only via reset.
- Alignment: redirect targets are loaded with bits [1:0] forced to 0 when the macro is not defined. `pc_plus4` is loaded as given.
- Wrap-around: `pc_plus4` of 32'hFFFF_FFFC is 0 (the adder wraps modulo 2^n); no special handling.
- Reset mid-operation clears all state immediately, including the pending redirect.

Optional Feature:
- Macro: `PC_MISALIGN_TRAP_EN`.
- When defined: when a redirect target with bits [1:0]≠0 is loaded (directly or from the pending register):
  - `pc` <= `TRAP_VECTOR` instead of the target.
  - `misalign_trap`=1 for exactly one cycle, coincident with the first cycle `pc`=`TRAP_VECTOR`.
- When undefined: low bits are masked to 0 and `misalign_trap` is tied 0.

Test Plan:
- Reset, then release; `imem_ready`=1 and `stall`=0 throughout → `pc`=0 and `fetch_valid`=0 in the BOOT cycle, then `fetch_valid`=1. `pc` sequence is 0, 4, 8, 12 on consecutive cycles (adder instantiated in the bench).
- At `pc`=8, assert `stall` for 3 cycles → `pc` stays 8 for 3 cycles, then 12.
- At `pc`=4, `imem_ready`=0 and a `redirect_valid` pulse with target 0x100; 2 cycles later `imem_ready`=1 → `pc` holds 4 until acceptance, then 0x100, then 0x104.
- At `pc`=0xFFFF_FFFC, advance → `pc`=0.
- Redirect to 0x102:
  - macro undefined → `pc`=0x100, `misalign_trap`=0.
  - macro defined → `pc`=0x80, `misalign_trap`=1 for one cycle.
- Assert `halt` at `pc`=0x10 → next cycle `halted`=1, `fetch_valid`=0, `pc`=0x10 held. Then pulse `rst_n` low asynchronously, mid-cycle → immediate `pc`=0, `halted`=0.
